mem_read_ctrl: RTL and testbench
================================

Name: mem_read_ctrl

Overview:
- Memory-to-processor read path: the counterpart of the MDDR store path, which moves A_bus data toward memory.
- On a control-unit read request, latches the address from AR and issues a single read to the synchronous data memory.
- Waits out a fixed memory latency, then captures the returned word into an internal data register (mdr_q).
- Drives mdr_q onto B_bus when the read decoder selects this register; otherwise drives zero.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: memory address width.
- MEM_LATENCY, 2: cycles (1..15) from the edge that samples mem_rd_en until the edge at which mem_data is captured, minus zero. L=1 means data is valid in the cycle right after the sampling edge.
- RD_SEL_BIT, 0: index of the RDec_out bit that selects mdr_q onto B_bus.

Ports:
- clock, in, 1: single system clock; all state updates on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- rd_start, in, 1: read request from the control unit; sampled only in IDLE.
- AR, in, ADDR_W: address register value, latched when rd_start is accepted.
- RDec_out, in, 19: one-hot read-decoder output.
- mem_data, in, DATA_W: read data from memory.
- mem_addr, out, ADDR_W: registered latched address.
- mem_rd_en, out, 1: memory read strobe.
- mdr_q, out, DATA_W: captured data register.
- B_bus, out, DATA_W: bus drive value.
- busy, out, 1: transaction in progress.
- done, out, 1: one-cycle completion pulse.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, addr_q=0, mdr_q=0, cnt=0, done=0.
  - Outputs therefore settle to mem_rd_en=0, busy=0, B_bus=0.
  - Reset takes priority over everything. Reset mid-transaction aborts it: no capture and no done pulse.
- States: IDLE, ISSUE, WAIT, CAPTURE. busy = (state != IDLE), combinational.
- IDLE:
  - At an edge with rd_start=1: addr_q <= AR; go to ISSUE.
  - rd_start=0: stay in IDLE.
- ISSUE:
  - mem_rd_en=1 (asserted only in ISSUE, exactly one cycle per transaction); mem_addr=addr_q.
  - Next edge: if MEM_LATENCY==1, go to CAPTURE. Otherwise load cnt <= MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement cnt each edge.
  - When cnt==1 at an edge, go to CAPTURE.
- CAPTURE:
  - mem_data is valid during this cycle.
  - Next edge: mdr_q <= mem_data; done <= 1; go to IDLE.
- Latency: if rd_start is accepted at edge E0, capture happens at edge E(1+MEM_LATENCY). done is high for the single cycle following that edge.
- done is registered and high for exactly one cycle. It is cleared at every other edge.
- rd_start while busy is ignored: no queueing and no address update.
- Back-to-back reads: rd_start asserted in the done cycle (state is IDLE) is accepted. There are zero dead cycles between transactions.
- mem_addr holds addr_q at all times. mem_addr and AR are ignored outside the accept edge.
- mdr_q holds its value until the next capture. It is unaffected by rd_start, RDec_out or aborted transactions.
- B_bus is combinational: B_bus = mdr_q only when RDec_out equals exactly the one-hot value with bit RD_SEL_BIT set; otherwise 0.
  - All-ones, all-zero or multi-hot decoder values drive 0.
  - B_bus shows the new value in the same cycle that done is high.
- Width rules:
  - cnt is 4 bits.
  - No arithmetic is performed on the data path.
  - The address is passed through unmodified.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/CAPTURE);
  - DATA_W/ADDR_W defaults;
  - RDEC_W=19 and WRDEC_W=20 constants;
  - a function onehot_is(vec, idx), returning 1 when vec equals exactly the one-hot value at idx. It is reused by the MDDR write path.
- One sub-module, lat_counter: loadable down-counter with a terminal flag (cnt==1), instantiated for the WAIT timing.

Test Plan:
1. Reset, then idle: reset_n=0 for 2 cycles, then 1 -> mdr_q=0x0000, B_bus=0, busy=0, mem_rd_en=0, done=0.
2. Basic read, MEM_LATENCY=2:
   - Stimulus: AR=0x0040, rd_start pulse at E0; memory returns 0xBEEF.
   - Response: mem_rd_en high only between E0 and E1 with mem_addr=0x0040; mdr_q=0xBEEF after E3; done high one cycle.
   - Then with RDec_out=19'b1 (bit 0), B_bus=0xBEEF.
3. Busy ignore and back-to-back:
   - Stimulus: rd_start with AR=0x0010; rd_start again mid-WAIT with AR=0x0020; third rd_start in the done cycle with AR=0x0030.
   - Response: only 0x0010 and 0x0030 appear on mem_addr; exactly two mem_rd_en pulses; 0x0020 is never issued.
4. Decoder select: mdr_q=0x1234.
   - RDec_out=19'h00001 -> B_bus=0x1234.
   - RDec_out=19'h00002 -> B_bus=0x0000.
   - RDec_out=19'h7FFFF -> B_bus=0x0000.
   - RDec_out=19'h00003 -> B_bus=0x0000.
5. Reset mid-operation: reset_n=0 during WAIT -> next cycle state IDLE, busy=0, mdr_q=0, no done pulse; the returning mem_data is not captured.
6. MEM_LATENCY=1 build: rd_start at E0, data 0xA5A5 -> capture at E2, done in the following cycle, WAIT state never entered.

Source files
------------

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory read path (mem_read_ctrl) and its
// write-path sibling.
//   - MEM_DATA_W / MEM_ADDR_W : default data and address widths
//   - RDEC_W / WRDEC_W        : read / write decoder vector widths
//   - CNT_W                   : width of the memory-latency counter
//   - state_t                 : read-controller states
//   - onehot_is()             : exact one-hot match of a decoder vector
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int RDEC_W     = 19;
  localparam int WRDEC_W    = 20;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // True only when vec is exactly the one-hot value with bit idx set.
  // Sized for the wider (write) decoder; read-decoder callers zero-extend.
  // Multi-hot, all-zero and all-ones vectors all return 0.
  function automatic logic onehot_is(input logic [WRDEC_W-1:0] vec,
                                     input int unsigned         idx);
    logic [WRDEC_W-1:0] ref_v;
    ref_v = {{(WRDEC_W-1){1'b0}}, 1'b1} << idx;
    return (vec == ref_v);
  endfunction

endpackage

// File: rtl/mem_read_ctrl_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Loadable down-counter that times the memory latency window.
//   clock    : system clock, rising edge
//   reset_n  : synchronous active-low reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one (saturates at zero)
//   cnt      : current count
//   term     : terminal flag, high while cnt == 1
// ---------------------------------------------------------------------------
module lat_counter
  import mem_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Terminal at 1, not 0: the edge that sees cnt==1 is the last WAIT edge.
  assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_read_ctrl.sv
// ---------------------------------------------------------------------------
// mem_read_ctrl
// Memory-to-processor read path. A control-unit read request latches AR,
// issues a single one-cycle read strobe to the synchronous data memory,
// waits out MEM_LATENCY, captures the returned word into mdr_q and drives
// mdr_q onto B_bus when the read decoder selects this register.
//
// Ports:
//   clock     : system clock, all state updates on the rising edge
//   reset_n   : synchronous active-low reset (aborts any transaction)
//   rd_start  : read request, only accepted in IDLE
//   AR        : address, latched on the accepting edge
//   RDec_out  : one-hot read-decoder output
//   mem_data  : read data from memory, valid during CAPTURE
//   mem_addr  : latched address (always addr_q)
//   mem_rd_en : read strobe, high for the single ISSUE cycle
//   mdr_q     : captured data register
//   B_bus     : mdr_q when RDec_out selects bit RD_SEL_BIT exactly, else 0
//   busy      : transaction in progress
//   done      : one-cycle registered completion pulse
//
// Timing: accept at edge E0 -> ISSUE, WAIT for MEM_LATENCY-1 cycles,
// CAPTURE, and mdr_q/done update at edge E(1+MEM_LATENCY).
// ---------------------------------------------------------------------------
module mem_read_ctrl
  import mem_pkg::*;
#(
  parameter int          DATA_W      = MEM_DATA_W,
  parameter int          ADDR_W      = MEM_ADDR_W,
  parameter int          MEM_LATENCY = 2,
  parameter int unsigned RD_SEL_BIT  = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] AR,
  input  logic [RDEC_W-1:0] RDec_out,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mdr_q,
  output logic [DATA_W-1:0] B_bus,
  output logic              busy,
  output logic              done
);

  // WAIT lasts MEM_LATENCY-1 cycles; unused when MEM_LATENCY == 1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              capture;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_term;
  logic [CNT_W-1:0]  cnt;

  lat_counter u_lat_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .term     (cnt_term)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start) state_d = ISSUE;
      ISSUE:   state_d = (MEM_LATENCY == 1) ? CAPTURE : WAIT;
      WAIT:    if (cnt_term) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    mem_rd_en = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    accept    = (state_q == IDLE) && rd_start;
    capture   = (state_q == CAPTURE);
    cnt_load  = (state_q == ISSUE);
    cnt_dec   = (state_q == WAIT);
  end

  // Address / data registers and completion pulse.
  // rd_start outside IDLE never reaches addr_q, so busy requests are dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q <= '0;
      mdr_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= capture;
      if (accept) begin
        addr_q <= AR;
      end
      if (capture) begin
        mdr_q <= mem_data;
      end
    end
  end

  assign mem_addr = addr_q;

  // Exact one-hot select: any other decoder pattern leaves the bus at zero.
  assign B_bus = onehot_is({{(WRDEC_W-RDEC_W){1'b0}}, RDec_out}, RD_SEL_BIT)
                 ? mdr_q : '0;

endmodule

// File: tb/tb_mem_read_ctrl.sv
module tb_mem_read_ctrl;
  import mem_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  // dut0: MEM_LATENCY = 2
  logic              rd_start0;
  logic [AW-1:0]     ar0;
  logic [RDEC_W-1:0] rdec0;
  logic [DW-1:0]     mem_data0;
  logic [AW-1:0]     mem_addr0;
  logic              mem_rd_en0;
  logic [DW-1:0]     mdr_q0;
  logic [DW-1:0]     b_bus0;
  logic              busy0;
  logic              done0;

  // dut1: MEM_LATENCY = 1
  logic              rd_start1;
  logic [AW-1:0]     ar1;
  logic [RDEC_W-1:0] rdec1;
  logic [DW-1:0]     mem_data1;
  logic [AW-1:0]     mem_addr1;
  logic              mem_rd_en1;
  logic [DW-1:0]     mdr_q1;
  logic [DW-1:0]     b_bus1;
  logic              busy1;
  logic              done1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_read_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(2), .RD_SEL_BIT(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .rd_start(rd_start0), .AR(ar0),
    .RDec_out(rdec0), .mem_data(mem_data0), .mem_addr(mem_addr0),
    .mem_rd_en(mem_rd_en0), .mdr_q(mdr_q0), .B_bus(b_bus0),
    .busy(busy0), .done(done0)
  );

  mem_read_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(1), .RD_SEL_BIT(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .rd_start(rd_start1), .AR(ar1),
    .RDec_out(rdec1), .mem_data(mem_data1), .mem_addr(mem_addr1),
    .mem_rd_en(mem_rd_en1), .mdr_q(mdr_q1), .B_bus(b_bus1),
    .busy(busy1), .done(done1)
  );

  // Synchronous memory models: the word is valid only in the cycle that is
  // MEM_LATENCY edges after the strobe is sampled; otherwise garbage.
  logic [DW-1:0] word0 = 16'h0000;
  logic [DW-1:0] word1 = 16'h0000;
  logic [1:0]    rdv0  = 2'b00;
  logic          rdv1  = 1'b0;

  always @(posedge clock) begin
    rdv0 <= {rdv0[0], mem_rd_en0};
    rdv1 <= mem_rd_en1;
  end

  assign mem_data0 = rdv0[1] ? word0 : 16'hDEAD;
  assign mem_data1 = rdv1    ? word1 : 16'hDEAD;

  // Strobe monitors
  int rd_pulses0 = 0;
  int addr20_pulses0 = 0;
  int wait_seen1 = 0;

  always @(posedge clock) begin
    if (mem_rd_en0 === 1'b1) begin
      rd_pulses0 <= rd_pulses0 + 1;
      if (mem_addr0 == 16'h0020) addr20_pulses0 <= addr20_pulses0 + 1;
    end
    if (dut1.state_q == WAIT) wait_seen1 <= wait_seen1 + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read0(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit got;
    got = 0;
    ar0 = addr;
    word0 = data;
    rd_start0 = 1'b1;
    tick();
    rd_start0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done0 === 1'b1) begin
        got = 1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL read_timeout: done never seen, addr %h", addr);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rdec0 = 19'h00001;
    tick();
    tick();
    reset_n = 1'b1;
    n_tests++; if (mdr_q0 !== 16'h0000) begin n_fail++; $display("FAIL reset_mdr: got %h want 0000", mdr_q0); end
    n_tests++; if (b_bus0 !== 16'h0000) begin n_fail++; $display("FAIL reset_bbus: got %h want 0000", b_bus0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_tests++; if (mem_rd_en0 !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %b want 0", mem_rd_en0); end
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_tests++; if (mem_addr0 !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr0); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    tick();
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy0); end
  endtask

  task automatic test_basic_read();
    rdec0 = 19'h00001;
    ar0 = 16'h0040;
    word0 = 16'hBEEF;
    rd_start0 = 1'b1;
    tick();  // E0
    rd_start0 = 1'b0;
    ar0 = 16'h9999;
    n_tests++; if (mem_rd_en0 !== 1'b1) begin n_fail++; $display("FAIL basic_rden_issue: got %b want 1", mem_rd_en0); end
    n_tests++; if (mem_addr0 !== 16'h0040) begin n_fail++; $display("FAIL basic_addr: got %h want 0040", mem_addr0); end
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy0); end
    tick();  // E1
    n_tests++; if (mem_rd_en0 !== 1'b0) begin n_fail++; $display("FAIL basic_rden_wait: got %b want 0", mem_rd_en0); end
    tick();  // E2
    n_tests++; if (done0 !== 1'b0 || mdr_q0 !== 16'h0000) begin n_fail++; $display("FAIL basic_early: done %b mdr %h want 0/0000", done0, mdr_q0); end
    tick();  // E3
    n_tests++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done0); end
    n_tests++; if (mdr_q0 !== 16'hBEEF) begin n_fail++; $display("FAIL basic_mdr: got %h want beef", mdr_q0); end
    n_tests++; if (b_bus0 !== 16'hBEEF) begin n_fail++; $display("FAIL basic_bbus: got %h want beef", b_bus0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy0); end
    n_tests++; if (mem_addr0 !== 16'h0040) begin n_fail++; $display("FAIL basic_addr_hold: got %h want 0040", mem_addr0); end
    tick();
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done0); end
    n_tests++; if (mdr_q0 !== 16'hBEEF) begin n_fail++; $display("FAIL basic_mdr_hold: got %h want beef", mdr_q0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    int a20;
    p0 = rd_pulses0;
    a20 = addr20_pulses0;
    ar0 = 16'h0010;
    word0 = 16'h1111;
    rd_start0 = 1'b1;
    tick();  // E0 accept
    rd_start0 = 1'b0;
    tick();  // E1 -> WAIT
    rd_start0 = 1'b1;
    ar0 = 16'h0020;
    tick();  // E2 -> CAPTURE, request ignored
    n_tests++; if (mem_addr0 !== 16'h0010) begin n_fail++; $display("FAIL b2b_ignore_addr: got %h want 0010", mem_addr0); end
    tick();  // E3 -> done cycle
    n_tests++; if (done0 !== 1'b1 || mdr_q0 !== 16'h1111) begin n_fail++; $display("FAIL b2b_first: done %b mdr %h want 1/1111", done0, mdr_q0); end
    ar0 = 16'h0030;
    word0 = 16'h3333;
    tick();  // E4 accepted in done cycle
    rd_start0 = 1'b0;
    n_tests++; if (mem_rd_en0 !== 1'b1 || mem_addr0 !== 16'h0030) begin n_fail++; $display("FAIL b2b_second_issue: rden %b addr %h want 1/0030", mem_rd_en0, mem_addr0); end
    tick();
    tick();
    tick();
    n_tests++; if (done0 !== 1'b1 || mdr_q0 !== 16'h3333) begin n_fail++; $display("FAIL b2b_second: done %b mdr %h want 1/3333", done0, mdr_q0); end
    tick();
    n_tests++; if (rd_pulses0 - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", rd_pulses0 - p0); end
    n_tests++; if (addr20_pulses0 - a20 !== 0) begin n_fail++; $display("FAIL b2b_addr20: got %0d want 0", addr20_pulses0 - a20); end
  endtask

  task automatic test_decoder();
    do_read0(16'h0100, 16'h1234);
    rdec0 = 19'h00001; #1;
    n_tests++; if (b_bus0 !== 16'h1234) begin n_fail++; $display("FAIL dec_bit0: got %h want 1234", b_bus0); end
    rdec0 = 19'h00002; #1;
    n_tests++; if (b_bus0 !== 16'h0000) begin n_fail++; $display("FAIL dec_bit1: got %h want 0000", b_bus0); end
    rdec0 = 19'h7FFFF; #1;
    n_tests++; if (b_bus0 !== 16'h0000) begin n_fail++; $display("FAIL dec_ones: got %h want 0000", b_bus0); end
    rdec0 = 19'h00003; #1;
    n_tests++; if (b_bus0 !== 16'h0000) begin n_fail++; $display("FAIL dec_multi: got %h want 0000", b_bus0); end
    rdec0 = 19'h00000; #1;
    n_tests++; if (b_bus0 !== 16'h0000) begin n_fail++; $display("FAIL dec_zero: got %h want 0000", b_bus0); end
    n_tests++; if (mdr_q0 !== 16'h1234) begin n_fail++; $display("FAIL dec_mdr_hold: got %h want 1234", mdr_q0); end
    rdec0 = 19'h00001;
  endtask

  task automatic test_reset_mid();
    bit bad;
    bad = 0;
    ar0 = 16'h0055;
    word0 = 16'h5555;
    rd_start0 = 1'b1;
    tick();  // E0 -> ISSUE
    rd_start0 = 1'b0;
    tick();  // E1 -> WAIT
    reset_n = 1'b0;
    tick();  // reset edge
    reset_n = 1'b1;
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    n_tests++; if (mdr_q0 !== 16'h0000) begin n_fail++; $display("FAIL rstmid_mdr: got %h want 0000", mdr_q0); end
    n_tests++; if (dut0.state_q !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", dut0.state_q, IDLE); end
    for (int i = 0; i < 5; i++) begin
      if (done0 !== 1'b0 || mdr_q0 !== 16'h0000 || mem_rd_en0 !== 1'b0) bad = 1;
      tick();
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL rstmid_no_capture: done %b mdr %h want 0/0000", done0, mdr_q0); end
  endtask

  task automatic test_lat1();
    int w0;
    w0 = wait_seen1;
    rdec1 = 19'h00001;
    ar1 = 16'h0077;
    word1 = 16'hA5A5;
    rd_start1 = 1'b1;
    tick();  // E0 -> ISSUE
    rd_start1 = 1'b0;
    n_tests++; if (mem_rd_en1 !== 1'b1 || mem_addr1 !== 16'h0077) begin n_fail++; $display("FAIL lat1_issue: rden %b addr %h want 1/0077", mem_rd_en1, mem_addr1); end
    tick();  // E1 -> CAPTURE
    n_tests++; if (busy1 !== 1'b1 || done1 !== 1'b0 || mdr_q1 !== 16'h0000) begin n_fail++; $display("FAIL lat1_capture: busy %b done %b mdr %h want 1/0/0000", busy1, done1, mdr_q1); end
    tick();  // E2 -> captured
    n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL lat1_done: got %b want 1", done1); end
    n_tests++; if (mdr_q1 !== 16'hA5A5 || b_bus1 !== 16'hA5A5) begin n_fail++; $display("FAIL lat1_data: mdr %h bus %h want a5a5", mdr_q1, b_bus1); end
    tick();
    n_tests++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL lat1_end: done %b busy %b want 0/0", done1, busy1); end
    n_tests++; if (wait_seen1 - w0 !== 0) begin n_fail++; $display("FAIL lat1_no_wait: got %0d want 0", wait_seen1 - w0); end
  endtask

  initial begin
    reset_n   = 1'b0;
    rd_start0 = 1'b0;
    ar0       = '0;
    rdec0     = '0;
    rd_start1 = 1'b0;
    ar1       = '0;
    rdec1     = '0;
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_decoder();
    test_reset_mid();
    test_lat1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
